// File: rtl/dt_ridge_pkg.sv
// Shared encodings and geometry for the distance-map ridge scanner.
package dt_ridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PIX,
    NBR,
    WRITE,
    FINISH
  } state_t;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned IMG_PIX = 16384;
  localparam int unsigned WORDS   = 1024;

  // N, W, E, S as 14-bit two's-complement offsets
  localparam logic [13:0] NBR_OFS [4] = '{14'h3F80, 14'h3FFF, 14'h0001, 14'h0080};

  function automatic logic [13:0] nbr_ofs(input logic [1:0] nb);
    return NBR_OFS[nb];
  endfunction

  function automatic logic is_interior(input logic [13:0] p);
    logic [6:0] r;
    logic [6:0] c;
    r = p[13:7];
    c = p[6:0];
    return (r != '0) && (r != 7'(IMG_W - 1)) && (c != '0) && (c != 7'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/dt_ridge.sv
// Raster scan of the distance map marking ridge pixels into the packed skeleton RAM,
// with running maximum distance and ridge-pixel count.
module dt_ridge
  import dt_ridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        map_rd,
  output logic [13:0] map_addr,
  input  logic [7:0]  map_di,
  output logic        skl_wr,
  output logic [9:0]  skl_addr,
  output logic [15:0] skl_do,
  output logic [7:0]  max_dist,
  output logic [13:0] ridge_cnt
);

  state_t      state, state_nx;
  logic [13:0] p;
  logic [1:0]  nb;
  logic [7:0]  center;
  logic        ok;
  logic [14:0] word_acc;

  logic interior, nz, ok_nx, word_end;
  logic pix_done, pix_bit, scan_go;

  assign interior = is_interior(p);
  assign nz       = (map_di != '0);
  assign ok_nx    = ok & (center >= map_di);
  assign word_end = (p[3:0] == 4'hF);

  assign done   = (state == FINISH);
  assign skl_wr = (state == WRITE);
  assign map_rd = (state == NBR) || ((state == PIX) && interior);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pix_done = 1'b0;
    pix_bit  = 1'b0;
    scan_go  = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nx = PIX;
          scan_go  = 1'b1;
        end
      end
      PIX: begin
        if (interior && nz) begin
          state_nx = NBR;
        end else begin
          pix_done = 1'b1;
          state_nx = word_end ? WRITE : PIX;
        end
      end
      NBR: begin
        if (nb == 2'd3) begin
          pix_done = 1'b1;
          pix_bit  = ok_nx;
          state_nx = word_end ? WRITE : PIX;
        end
      end
      WRITE:   state_nx = (skl_addr == 10'(WORDS - 1)) ? FINISH : PIX;
      default: state_nx = IDLE;
    endcase
  end

  // map_addr is loaded one cycle ahead so it is stable for the whole read cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p         <= '0;
      nb        <= '0;
      center    <= '0;
      ok        <= 1'b0;
      word_acc  <= '0;
      map_addr  <= '0;
      skl_addr  <= '0;
      skl_do    <= '0;
      max_dist  <= '0;
      ridge_cnt <= '0;
    end else begin
      if (scan_go) begin
        p         <= '0;
        nb        <= '0;
        ok        <= 1'b0;
        word_acc  <= '0;
        map_addr  <= '0;
        max_dist  <= '0;
        ridge_cnt <= '0;
      end
      if ((state == PIX) && interior && nz) begin
        center   <= map_di;
        ok       <= 1'b1;
        nb       <= '0;
        map_addr <= p + nbr_ofs(2'd0);
        if (map_di > max_dist) max_dist <= map_di;
      end
      if (state == NBR) begin
        ok <= ok_nx;
        nb <= nb + 2'd1;
        if (nb != 2'd3) map_addr <= p + nbr_ofs(nb + 2'd1);
      end
      if (pix_done) begin
        word_acc  <= {word_acc[13:0], pix_bit};
        p         <= p + 14'd1;
        map_addr  <= p + 14'd1;
        ridge_cnt <= ridge_cnt + 14'(pix_bit);
        if (word_end) begin
          skl_do   <= {word_acc, pix_bit};
          skl_addr <= p[13:4];
        end
      end
    end
  end

endmodule

// File: tb/tb_dt_ridge.sv
// Scoreboard bench for dt_ridge: a reference model fills expected read and write queues,
// a negedge monitor pops and compares them as the DUT strobes map_rd / skl_wr.
module tb_dt_ridge;
  import dt_ridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        map_rd;
  logic [13:0] map_addr;
  logic [7:0]  map_di;
  logic        skl_wr;
  logic [9:0]  skl_addr;
  logic [15:0] skl_do;
  logic [7:0]  max_dist;
  logic [13:0] ridge_cnt;

  logic [7:0]  map_mem [IMG_PIX];
  int          rd_q [$];
  logic [25:0] wr_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  int exp_nz, exp_ridge, exp_max;

  always #5 clk = ~clk;
  assign map_di = map_mem[map_addr];

  dt_ridge dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .map_rd(map_rd), .map_addr(map_addr), .map_di(map_di),
    .skl_wr(skl_wr), .skl_addr(skl_addr), .skl_do(skl_do),
    .max_dist(max_dist), .ridge_cnt(ridge_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: ridge = interior, non-zero, >= all four neighbours
  task automatic build_expect(output int nz, output int ridge, output int mx);
    logic [15:0] w;
    int r, c, v;
    logic b;
    nz = 0; ridge = 0; mx = 0; w = '0;
    rd_q.delete();
    wr_q.delete();
    for (int p = 0; p < int'(IMG_PIX); p++) begin
      r = p / 128;
      c = p % 128;
      v = int'(map_mem[p]);
      b = 1'b0;
      if (r > 0 && r < 127 && c > 0 && c < 127) begin
        rd_q.push_back(p);
        if (v != 0) begin
          nz++;
          if (v > mx) mx = v;
          rd_q.push_back(p - 128);
          rd_q.push_back(p - 1);
          rd_q.push_back(p + 1);
          rd_q.push_back(p + 128);
          b = (v >= int'(map_mem[p-128])) && (v >= int'(map_mem[p-1])) &&
              (v >= int'(map_mem[p+1]))   && (v >= int'(map_mem[p+128]));
          if (b) ridge++;
        end
      end
      w[15 - (p % 16)] = b;
      if (p % 16 == 15) wr_q.push_back({10'(p / 16), w});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (map_rd) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL map_rd_extra: got read at %0d expected no read", map_addr);
        end else begin
          check("map_addr", 32'(map_addr), 32'(rd_q.pop_front()));
        end
      end
      if (skl_wr) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL skl_wr_extra: got write at %0d expected no write", skl_addr);
        end else begin
          logic [25:0] e;
          e = wr_q.pop_front();
          check("skl_addr", 32'(skl_addr), 32'(e[25:16]));
          check("skl_do", 32'(skl_do), 32'(e[15:0]));
        end
      end
    end
  end

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(input int exp_cyc, input bit pulses);
    int cyc;
    bit got;
    cyc = 0; got = 1'b0;
    while (!got && cyc < exp_cyc + 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = pulses && (cyc == 100 || cyc == 9000);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_reached", 32'(got), 32'd1);
    check("scan_cycles", 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic check_final(input string tag);
    @(negedge clk);
    check({tag, "_ridge_cnt"}, 32'(ridge_cnt), 32'(exp_ridge));
    check({tag, "_max_dist"}, 32'(max_dist), 32'(exp_max));
    check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_map_rd"}, 32'(map_rd), 32'd0);
    check({tag, "_skl_wr"}, 32'(skl_wr), 32'd0);
    check({tag, "_map_addr"}, 32'(map_addr), 32'd0);
    check({tag, "_skl_addr"}, 32'(skl_addr), 32'd0);
    check({tag, "_skl_do"}, 32'(skl_do), 32'd0);
    check({tag, "_max_dist"}, 32'(max_dist), 32'd0);
    check({tag, "_ridge_cnt"}, 32'(ridge_cnt), 32'd0);
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < int'(IMG_PIX); i++) map_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("por");
    @(negedge clk) reset = 1'b1;

    // directed map: lone pixel, 3x3 peak, border-only values
    map_mem[5*128 + 5] = 8'd1;
    for (int r = 10; r <= 12; r++)
      for (int c = 20; c <= 22; c++)
        map_mem[r*128 + c] = (r == 11 && c == 21) ? 8'd2 : 8'd1;
    map_mem[0] = 8'd9;
    map_mem[127*128 + 127] = 8'd9;
    build_expect(exp_nz, exp_ridge, exp_max);
    check("model_ridge", 32'(exp_ridge), 32'd6);

    // abort during the E-neighbour read of (5,5)
    mon_en = 1'b1;
    kick();
    waited = 0;
    while (!(map_rd && map_addr == 14'd646) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("abort_point_reached", 32'(waited < 2000), 32'd1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1 check_reset_vals("abort");
    @(posedge clk);
    #1 check_reset_vals("abort_hold");
    @(negedge clk) reset = 1'b1;

    build_expect(exp_nz, exp_ridge, exp_max);
    mon_en = 1'b1;
    kick();
    run_to_done(16384 + 4*exp_nz + 1024, 1'b1);
    check_final("directed");
    repeat (5) @(negedge clk);
    check("finish_hold_done", 32'(done), 32'd1);
    check("finish_hold_ridge", 32'(ridge_cnt), 32'(exp_ridge));

    // restart from FINISH: identical result, stats cleared first
    build_expect(exp_nz, exp_ridge, exp_max);
    kick();
    check("restart_done_low", 32'(done), 32'd0);
    check("restart_ridge_clr", 32'(ridge_cnt), 32'd0);
    check("restart_max_clr", 32'(max_dist), 32'd0);
    run_to_done(16384 + 4*exp_nz + 1024, 1'b0);
    check_final("restart");

    // random dense patch plus scattered values anywhere, including borders
    for (int i = 0; i < int'(IMG_PIX); i++) map_mem[i] = '0;
    for (int r = 40; r < 60; r++)
      for (int c = 30; c < 90; c++) begin
        int sel;
        sel = int'($urandom_range(0, 15));
        map_mem[r*128 + c] = (sel < 5) ? 8'd0 :
                             (sel < 14) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(128, 255));
      end
    for (int i = 0; i < 24; i++) map_mem[$urandom_range(0, IMG_PIX - 1)] = 8'($urandom_range(1, 255));
    build_expect(exp_nz, exp_ridge, exp_max);
    kick();
    run_to_done(16384 + 4*exp_nz + 1024, 1'b0);
    check_final("random");

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
